pattern_detect_ctrl: RTL and testbench



---
 rtl/pattern_detect_ctrl.sv | 79 +++++++
 tb/tb_pattern_detect_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: programmable serial pattern detector with arm/abort, overlap control and match-count target
module pattern_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x_valid,
  input  logic               x,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
  state_t state, state_n;
  logic [MAX_LEN-1:0] pat, hist, hist_n, mask;
  logic [LW-1:0] len, fill, fill_n;
  logic [CNT_W-1:0] tgt, cnt_n;
  logic ovl, cfg_ok, acc, hit, go;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    cfg_ok = cfg_wr && state != RUN && cfg_len != '0 && cfg_len <= MAXL;
    acc = state == RUN && !abort && x_valid;
    hist_n = {hist[MAX_LEN-2:0], x};
    fill_n = fill == MAXL ? fill : fill + 1'b1;
    mask = ~({MAX_LEN{1'b1}} << len);
    hit = acc && fill_n >= len && ((hist_n ^ pat) & mask) == '0;
    cnt_n = &match_count ? match_count : match_count + 1'b1;
    state_n = state == RUN ? (abort ? IDLE : (hit && tgt != '0 && cnt_n == tgt) ? DONE : RUN)
            : (state == DONE && abort) ? IDLE : start ? RUN : state;
    go = state != RUN && state_n == RUN;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= MAX_LEN'(4'b1001);
      len <= LW'(4);
      ovl <= 1'b1;
      tgt <= '0;
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
      match_count <= '0;
      cfg_err <= 1'b0;
    end else begin
      match <= hit;
      cfg_err <= cfg_wr && !cfg_ok;
      if (cfg_ok) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
        tgt <= cfg_target;
      end
      if (go) begin
        hist <= '0;
        fill <= '0;
        match_count <= '0;
      end else if (acc) begin
        hist <= hist_n;
        fill <= (hit && !ovl) ? '0 : fill_n;
        if (hit) match_count <= cnt_n;
      end
    end
  end
endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// tb_pattern_detect_ctrl: directed and random checks of pattern_detect_ctrl against a bit-queue reference model
module tb_pattern_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W = 8;
  localparam int LW = $clog2(MAX_LEN + 1);
  logic clk = 0, rst = 1, cfg_wr = 0, cfg_overlap = 0, start = 0, abort = 0, x_valid = 0, x = 0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic busy, done, match, cfg_err;
  logic [CNT_W-1:0] match_count;
  int n_vec = 0, n_err = 0;
  int m_st, m_len, m_tgt, m_cnt;
  bit m_ovl, e_match, e_err;
  bit [MAX_LEN-1:0] m_pat;
  bit q[$];

  pattern_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .x_valid(x_valid), .x(x), .busy(busy), .done(done), .match(match),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: the bits seen since the run started (or since the last non-overlapping match);
  // a match is simply the newest len bits equalling the pattern.
  task automatic model();
    bit hit;
    e_match = 0;
    e_err = 0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_pat = 8'b1001; m_len = 4; m_ovl = 1; m_tgt = 0;
      q.delete();
      return;
    end
    if (cfg_wr) begin
      if (m_st != 1 && int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
      end else e_err = 1;
    end
    if (m_st == 1) begin
      if (abort) m_st = 0;
      else if (x_valid) begin
        q.push_back(x);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        hit = q.size() >= m_len;
        for (int i = 0; i < m_len && hit; i++)
          if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
        if (hit) begin
          e_match = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) q.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
        end
      end
    end else if (m_st == 2 && abort) m_st = 0;
    else if (start) begin
      m_st = 1; m_cnt = 0;
      q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    n_vec++;
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("match", match, e_match);
    chk("match_count", match_count, m_cnt);
    chk("cfg_err", cfg_err, e_err);
  endtask

  task automatic send(input bit b, input int gap);
    repeat (gap) begin x_valid = 0; x = 1'($urandom); tick(); end
    x_valid = 1; x = b; tick();
    x_valid = 0;
  endtask

  task automatic send_seq(input logic [15:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--) send(v[i], $urandom_range(0, maxgap));
  endtask

  task automatic cfg(input logic [7:0] p, input int l, input bit o, input int t);
    cfg_wr = 1; cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o; cfg_target = CNT_W'(t);
    tick();
    cfg_wr = 0;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  task automatic stop();
    abort = 1; tick(); abort = 0;
  endtask

  initial begin
    rst = 1; tick(); tick(); rst = 0;
    chk("reset_count", match_count, 0);
    // reset-default pattern with overlap
    go();
    send_seq(16'b1001001, 7, 0);
    chk("overlap_count", match_count, 2);
    chk("overlap_busy", busy, 1);
    // no overlap, then continuation
    stop();
    cfg(8'b1001, 4, 0, 0);
    go();
    send_seq(16'b1001001, 7, 0);
    chk("noovl_count", match_count, 1);
    send_seq(16'b001001, 6, 0);
    chk("noovl_count2", match_count, 2);
    // target stop with valid gaps
    stop();
    cfg(8'b1001, 4, 1, 2);
    go();
    send_seq(16'b1001001, 7, 3);
    chk("target_done", done, 1);
    chk("target_busy", busy, 0);
    send_seq(16'b1001, 4, 0);
    chk("target_hold", match_count, 2);
    // rejected configuration writes
    cfg(8'b0110, 0, 1, 0);
    cfg(8'b0110, MAX_LEN + 1, 1, 0);
    go();
    cfg(8'b0110, 4, 1, 0);
    send_seq(16'b1001, 4, 1);
    chk("cfg_unchanged", match_count, 1);
    // abort on the completing bit
    stop();
    cfg(8'b1001, 4, 1, 0);
    go();
    send_seq(16'b1001100, 7, 0);
    x_valid = 1; x = 1; abort = 1; tick();
    x_valid = 0; abort = 0;
    chk("abort_match", match, 0);
    chk("abort_count", match_count, 1);
    chk("abort_busy", busy, 0);
    go();
    chk("restart_count", match_count, 0);
    // reset mid-run
    send_seq(16'b100, 3, 0);
    rst = 1; tick(); rst = 0;
    chk("midrst_busy", busy, 0);
    go();
    send(1, 0);
    chk("midrst_nomatch", match, 0);
    send_seq(16'b001, 3, 0);
    chk("midrst_default_cfg", match_count, 1);
    // len 1 pulse train and saturation
    stop();
    cfg(8'b1, 1, 1, 0);
    go();
    for (int i = 0; i < 260; i++) send(1, 0);
    chk("saturate", match_count, 255);
    chk("train_match", match, 1);
    stop();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cfg_wr = ($urandom % 20) == 0;
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len = LW'($urandom_range(0, MAX_LEN + 1));
      cfg_overlap = 1'($urandom);
      cfg_target = CNT_W'($urandom_range(0, 4));
      start = ($urandom % 12) == 0;
      abort = ($urandom % 50) == 0;
      x_valid = ($urandom % 4) != 0;
      x = 1'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
